// File: rtl/gray_preproc.sv
// RGB565 -> 8/4-bit luma pipeline (3-cycle latency) with de/x/y carried alongside,
// plus per-frame average-luma metering over a centred 512x256 window.
module gray_preproc #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int WIN_X0     = 64,
  parameter int WIN_Y0     = 112
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] i_rgb565,
  input  logic        i_de,
  input  logic [9:0]  i_x,
  input  logic [8:0]  i_y,
  output logic [3:0]  o_gray,
  output logic        o_de,
  output logic [9:0]  o_x,
  output logic [8:0]  o_y,
  output logic [7:0]  o_luma8,
  output logic [3:0]  o_frame_avg,
  output logic        o_avg_valid
);

  localparam int WIN_W = 512;
  localparam int WIN_H = 256;

  localparam logic [31:0] WX_LO = WIN_X0;
  localparam logic [31:0] WX_HI = WIN_X0 + WIN_W;
  localparam logic [31:0] WY_LO = WIN_Y0;
  localparam logic [31:0] WY_HI = WIN_Y0 + WIN_H;
  localparam logic [9:0]  X_LAST = 10'(IMG_WIDTH - 1);
  localparam logic [8:0]  Y_LAST = 9'(IMG_HEIGHT - 1);

  logic [7:0]  s1_r, s1_g, s1_b;
  logic        s1_de;
  logic [9:0]  s1_x;
  logic [8:0]  s1_y;

  logic [15:0] s2_pr, s2_pg, s2_pb;
  logic        s2_de;
  logic [9:0]  s2_x;
  logic [8:0]  s2_y;

  logic [7:0]  luma;

  logic [24:0] acc;
  logic [24:0] acc_next;
  logic        frame_active;
  logic        in_win;
  logic        sample;
  logic        frame_start;
  logic        frame_end;
  logic [31:0] x_ext;
  logic [31:0] y_ext;

  // Stage 1: widen channels to 8 bits by replicating the MSBs into the LSBs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_r  <= '0;
      s1_g  <= '0;
      s1_b  <= '0;
      s1_de <= 1'b0;
      s1_x  <= '0;
      s1_y  <= '0;
    end else begin
      s1_r  <= {i_rgb565[15:11], i_rgb565[15:13]};
      s1_g  <= {i_rgb565[10:5],  i_rgb565[10:9]};
      s1_b  <= {i_rgb565[4:0],   i_rgb565[4:2]};
      s1_de <= i_de;
      s1_x  <= i_x;
      s1_y  <= i_y;
    end
  end

  // Stage 2: BT.601-style weights scaled to 256 (77 + 150 + 29)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_pr <= '0;
      s2_pg <= '0;
      s2_pb <= '0;
      s2_de <= 1'b0;
      s2_x  <= '0;
      s2_y  <= '0;
    end else begin
      s2_pr <= {8'd0, s1_r} * 16'd77;
      s2_pg <= {8'd0, s1_g} * 16'd150;
      s2_pb <= {8'd0, s1_b} * 16'd29;
      s2_de <= s1_de;
      s2_x  <= s1_x;
      s2_y  <= s1_y;
    end
  end

  // Weights sum to 256, so the total never exceeds 16 bits
  assign luma = 8'((s2_pr + s2_pg + s2_pb) >> 8);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_luma8 <= '0;
      o_gray  <= '0;
      o_de    <= 1'b0;
      o_x     <= '0;
      o_y     <= '0;
    end else begin
      o_luma8 <= s2_de ? luma : 8'd0;
      o_gray  <= s2_de ? luma[7:4] : 4'd0;
      o_de    <= s2_de;
      o_x     <= s2_x;
      o_y     <= s2_y;
    end
  end

  // Metering observes the stage-3 outputs so it sees exactly what downstream sees
  assign x_ext       = {22'd0, o_x};
  assign y_ext       = {23'd0, o_y};
  assign in_win      = (x_ext >= WX_LO) && (x_ext < WX_HI) &&
                       (y_ext >= WY_LO) && (y_ext < WY_HI);
  assign sample      = o_de && in_win;
  assign frame_start = o_de && (o_x == 10'd0) && (o_y == 9'd0);
  assign frame_end   = o_de && (o_x == X_LAST) && (o_y == Y_LAST);

  always_comb begin
    acc_next = acc;
    if (frame_start) begin
      acc_next = sample ? {17'd0, o_luma8} : 25'd0;
    end else if (frame_active && sample) begin
      acc_next = acc + {17'd0, o_luma8};
    end
  end

  // Only a frame whose start was seen may publish; acc freezes after its end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc          <= '0;
      frame_active <= 1'b0;
      o_frame_avg  <= '0;
      o_avg_valid  <= 1'b0;
    end else begin
      acc         <= acc_next;
      o_avg_valid <= 1'b0;
      if (frame_end && (frame_active || frame_start)) begin
        o_frame_avg  <= acc_next[24:21];
        o_avg_valid  <= 1'b1;
        frame_active <= 1'b0;
      end else if (frame_start) begin
        frame_active <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gray_preproc.sv
// Bench for gray_preproc: table vectors and bursts checked through a latency
// scoreboard, plus reduced-size frames that exercise the metering thresholds.
module tb_gray_preproc;

  logic        clk;
  logic        reset;
  logic [15:0] i_rgb565;
  logic        i_de;
  logic [9:0]  i_x;
  logic [8:0]  i_y;
  logic [3:0]  o_gray;
  logic        o_de;
  logic [9:0]  o_x;
  logic [8:0]  o_y;
  logic [7:0]  o_luma8;
  logic [3:0]  o_frame_avg;
  logic        o_avg_valid;

  gray_preproc #(
    .IMG_WIDTH (640),
    .IMG_HEIGHT(480),
    .WIN_X0    (64),
    .WIN_Y0    (112)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_rgb565   (i_rgb565),
    .i_de       (i_de),
    .i_x        (i_x),
    .i_y        (i_y),
    .o_gray     (o_gray),
    .o_de       (o_de),
    .o_x        (o_x),
    .o_y        (o_y),
    .o_luma8    (o_luma8),
    .o_frame_avg(o_frame_avg),
    .o_avg_valid(o_avg_valid)
  );

  typedef struct {
    logic [15:0] rgb;
    logic        de;
    logic [7:0]  luma;
    logic [3:0]  gray;
  } vec_t;

  typedef struct {
    int         due;
    logic       de;
    logic [9:0] x;
    logic [8:0] y;
    logic [7:0] luma;
    logic [3:0] gray;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[8];

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int pulse_cnt = 0;
  int pulse_cyc = -1;
  logic [3:0] pulse_avg = 4'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] lumaModel(input logic [15:0] rgb);
    int r8, g8, b8;
    r8 = (int'(rgb[15:11]) << 3) | (int'(rgb[15:11]) >> 2);
    g8 = (int'(rgb[10:5])  << 2) | (int'(rgb[10:5])  >> 4);
    b8 = (int'(rgb[4:0])   << 3) | (int'(rgb[4:0])   >> 2);
    return 8'((r8 * 77 + g8 * 150 + b8 * 29) >> 8);
  endfunction

  // One clock: drive after the edge, then retire due scoreboard entries at the falling edge
  task automatic applyStimulus(input logic [15:0] rgb, input logic de, input logic [9:0] x,
                               input logic [8:0] y, input bit chk,
                               input logic [7:0] luma, input logic [3:0] gray);
    exp_t e;
    @(posedge clk);
    #1;
    i_rgb565 = rgb;
    i_de     = de;
    i_x      = x;
    i_y      = y;
    if (chk) sb.push_back('{cyc + 3, de, x, y, de ? luma : 8'd0, de ? gray : 4'd0});
    @(negedge clk);
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      checkOutput("o_de",    32'(o_de),    32'(e.de));
      checkOutput("o_x",     32'(o_x),     32'(e.x));
      checkOutput("o_y",     32'(o_y),     32'(e.y));
      checkOutput("o_luma8", 32'(o_luma8), 32'(e.luma));
      checkOutput("o_gray",  32'(o_gray),  32'(e.gray));
    end
    if (o_avg_valid) begin
      pulse_cnt++;
      pulse_cyc = cyc;
      pulse_avg = o_frame_avg;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(16'h0000, 1'b0, 10'd0, 9'd0, 1'b0, 8'd0, 4'd0);
  endtask

  // Frame with only the pixels that matter: optional start, window samples, decoys, end
  task automatic runFrame(input bit with_start, input int n_win, input int y_base,
                          input bit decoys, output int end_cyc);
    if (with_start) applyStimulus(16'hFFFF, 1'b1, 10'd0, 9'd0, 1'b0, 8'd0, 4'd0);
    for (int i = 0; i < n_win; i++)
      applyStimulus(16'hFFFF, 1'b1, 10'(64 + i % 512), 9'(y_base + i / 512), 1'b0, 8'd0, 4'd0);
    if (decoys) begin
      applyStimulus(16'hFFFF, 1'b1, 10'd63,  9'd120, 1'b0, 8'd0, 4'd0);
      applyStimulus(16'hFFFF, 1'b1, 10'd576, 9'd120, 1'b0, 8'd0, 4'd0);
      applyStimulus(16'hFFFF, 1'b1, 10'd100, 9'd111, 1'b0, 8'd0, 4'd0);
      applyStimulus(16'hFFFF, 1'b1, 10'd100, 9'd368, 1'b0, 8'd0, 4'd0);
      applyStimulus(16'hFFFF, 1'b0, 10'd100, 9'd120, 1'b0, 8'd0, 4'd0);
      applyStimulus(16'hFFFF, 1'b1, 10'd700, 9'd500, 1'b0, 8'd0, 4'd0);
    end
    applyStimulus(16'hFFFF, 1'b1, 10'd639, 9'd479, 1'b0, 8'd0, 4'd0);
    end_cyc = cyc;
    idle(8);
  endtask

  task automatic checkFrame(input string name, input int p0, input int end_cyc,
                            input int exp_pulses, input int n_win);
    logic [31:0] exp_avg;
    exp_avg = 32'((n_win * 255) >> 21);
    checkOutput({name, "_pulses"}, 32'(pulse_cnt - p0), 32'(exp_pulses));
    if (exp_pulses == 1) begin
      checkOutput({name, "_pulse_cycle"}, 32'(pulse_cyc), 32'(end_cyc + 4));
      checkOutput({name, "_pulse_avg"},   32'(pulse_avg), exp_avg);
      checkOutput({name, "_avg_held"},    32'(o_frame_avg), exp_avg);
    end
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, "_de"},    32'(o_de),        32'd0);
    checkOutput({name, "_gray"},  32'(o_gray),      32'd0);
    checkOutput({name, "_luma"},  32'(o_luma8),     32'd0);
    checkOutput({name, "_x"},     32'(o_x),         32'd0);
    checkOutput({name, "_y"},     32'(o_y),         32'd0);
    checkOutput({name, "_avg"},   32'(o_frame_avg), 32'd0);
    checkOutput({name, "_valid"}, 32'(o_avg_valid), 32'd0);
  endtask

  initial begin
    int p0;
    int end_cyc;
    logic [15:0] burst_rgb [5];
    logic        burst_de  [5];
    logic [7:0]  l;

    tbl[0] = '{16'hFFFF, 1'b1, 8'd255, 4'd15};
    tbl[1] = '{16'hF800, 1'b1, 8'd76,  4'd4};
    tbl[2] = '{16'h07E0, 1'b1, 8'd149, 4'd9};
    tbl[3] = '{16'h001F, 1'b1, 8'd28,  4'd1};
    tbl[4] = '{16'h0000, 1'b1, 8'd0,   4'd0};
    tbl[5] = '{16'h8410, 1'b1, 8'd130, 4'd8};
    tbl[6] = '{16'h7BEF, 1'b1, 8'd124, 4'd7};
    tbl[7] = '{16'hFFFF, 1'b0, 8'd0,   4'd0};
    burst_rgb = '{16'h1234, 16'hABCD, 16'h8410, 16'hF81F, 16'h07FF};
    burst_de  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    reset = 1'b1;
    i_rgb565 = '0;
    i_de = 1'b0;
    i_x = '0;
    i_y = '0;
    #12;
    checkAllZero("por");
    reset = 1'b0;

    for (int i = 0; i < 8; i++)
      applyStimulus(tbl[i].rgb, tbl[i].de, 10'(100 + i), 9'd50, 1'b1, tbl[i].luma, tbl[i].gray);
    for (int i = 0; i < 3; i++) applyStimulus(16'h0000, 1'b0, 10'd0, 9'd0, 1'b1, 8'd0, 4'd0);

    for (int i = 0; i < 5; i++) begin
      l = lumaModel(burst_rgb[i]);
      applyStimulus(burst_rgb[i], burst_de[i], 10'(10 + i), 9'd3, 1'b1, l, l[7:4]);
    end
    for (int i = 0; i < 4; i++) applyStimulus(16'h0000, 1'b0, 10'd0, 9'd0, 1'b1, 8'd0, 4'd0);

    p0 = pulse_cnt;
    runFrame(1'b1, 8225, 112, 1'b1, end_cyc);
    checkFrame("frameA", p0, end_cyc, 1, 8225);

    // Reset while pixels are streaming and o_frame_avg is non-zero
    for (int i = 0; i < 4; i++)
      applyStimulus(16'hFFFF, 1'b1, 10'(5 + i), 9'd7, 1'b1, 8'd255, 4'd15);
    #2;
    reset = 1'b1;
    sb.delete();
    #1;
    checkAllZero("midrst");
    applyStimulus(16'hFFFF, 1'b1, 10'd20, 9'd30, 1'b0, 8'd0, 4'd0);
    reset = 1'b0;
    applyStimulus(16'hFFFF, 1'b1, 10'd21, 9'd30, 1'b1, 8'd255, 4'd15);
    checkOutput("rel_c1_de", 32'(o_de), 32'd0);
    applyStimulus(16'hFFFF, 1'b1, 10'd22, 9'd30, 1'b1, 8'd255, 4'd15);
    checkOutput("rel_c2_de", 32'(o_de), 32'd0);
    applyStimulus(16'hFFFF, 1'b1, 10'd23, 9'd30, 1'b1, 8'd255, 4'd15);
    checkOutput("rel_c3_de", 32'(o_de), 32'd1);
    checkOutput("rel_c3_x",  32'(o_x),  32'd20);
    checkOutput("rel_c3_luma", 32'(o_luma8), 32'd255);
    idle(4);

    // Reset released mid-frame: the tail of that frame must not publish
    #2;
    reset = 1'b1;
    sb.delete();
    idle(1);
    reset = 1'b0;
    p0 = pulse_cnt;
    runFrame(1'b0, 8225, 200, 1'b0, end_cyc);
    checkFrame("partial", p0, end_cyc, 0, 8225);
    checkOutput("partial_avg", 32'(o_frame_avg), 32'd0);

    p0 = pulse_cnt;
    runFrame(1'b1, 8225, 112, 1'b0, end_cyc);
    checkFrame("after_partial", p0, end_cyc, 1, 8225);

    // One sample short of the threshold: any stale or out-of-window sum would read 1
    p0 = pulse_cnt;
    runFrame(1'b1, 8224, 112, 1'b1, end_cyc);
    checkFrame("frameB", p0, end_cyc, 1, 8224);

    for (int k = 0; k < 10 && sb.size() > 0; k++) idle(1);
    checkOutput("sb_drain", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
